// File: rtl/time_link_pkg.sv
// Shared definitions for the network-time fetch link. Both the responder and the
// initiator use these, as do their benches.
//   REQ_BYTE_DEF / HDR_BYTE_DEF : default request command and response header
//   FRAME_BYTES                 : response frame length in bytes
//   rx_state_t / tx_state_t     : RX byte receiver and TX frame sequencer states
// Build option: TIME_RESP_CHECKSUM_EN adds a trailing XOR checksum byte to the frame.
package time_link_pkg;

  localparam logic [7:0] REQ_BYTE_DEF = 8'h54;
  localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;

`ifdef TIME_RESP_CHECKSUM_EN
  localparam int FRAME_BYTES = 6;
`else
  localparam int FRAME_BYTES = 5;
`endif

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_PEND,
    TX_SEND
  } tx_state_t;

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serialiser, LSB first, BIT_CYC clock cycles per bit.
//   clk, reset_n : system clock, synchronous active-low reset
//   start        : request to send data (taken when ready is high)
//   data         : byte to send
//   ready        : high when a new byte can be taken this cycle; this includes the
//                  last cycle of a stop bit so bytes can go out back to back
//   tx           : serial line, idle high
module uart_byte_tx #(
  parameter int BIT_CYC = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam int CW = $clog2(BIT_CYC + 1);

  logic          r_active;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_bit;
  logic [8:0]    r_shift;
  logic          r_tx;
  logic          w_bit_end;

  assign w_bit_end = (r_cnt == CW'(BIT_CYC - 1));
  assign ready     = !r_active || (w_bit_end && (r_bit == 4'd9));
  assign tx        = r_tx;

  // r_bit: 0 = start bit, 1..8 = data bits, 9 = stop bit
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_active <= 1'b0;
      r_tx     <= 1'b1;
      r_cnt    <= '0;
      r_bit    <= '0;
    end else if (start && ready) begin
      r_active <= 1'b1;
      r_tx     <= 1'b0;
      r_cnt    <= '0;
      r_bit    <= '0;
    end else if (r_active) begin
      if (w_bit_end) begin
        r_cnt <= '0;
        if (r_bit == 4'd9) begin
          r_active <= 1'b0;
        end else begin
          r_tx  <= r_shift[0];
          r_bit <= r_bit + 4'd1;
        end
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // Stop bit rides in at the top so it falls out after the eighth data bit.
  always_ff @(posedge clk) begin
    if (start && ready) begin
      r_shift <= {1'b1, data};
    end else if (r_active && w_bit_end && (r_bit != 4'd9)) begin
      r_shift <= {1'b1, r_shift[8:1]};
    end
  end

endmodule

// File: rtl/uart_time_responder.sv
// Responder end of the network-time fetch link. Receives a one-byte time request
// over UART and answers with a framed snapshot of a free-running epoch-seconds counter.
//   clk        : system clock (CLK_HZ; also the 1 Hz epoch tick divisor)
//   reset_n    : synchronous active-low reset
//   rx_pin     : UART receive line, asynchronous, idle high
//   tx_pin     : UART transmit line, idle high
//   set_en     : one-cycle strobe loading set_value into the epoch counter
//   set_value  : epoch value to load
//   epoch      : current epoch-seconds counter
//   busy       : high while a response frame is on the line
//   req_drop   : one-cycle pulse when a request arrives while a response is in flight
// Frame: HDR_BYTE, epoch[31:24], [23:16], [15:8], [7:0], each 8N1 back to back.
// Build option: TIME_RESP_CHECKSUM_EN appends an XOR of the four epoch bytes.
module uart_time_responder
  import time_link_pkg::*;
#(
  parameter int         CLK_HZ   = 100_000_000,
  parameter int         BAUD     = 115200,
  parameter logic [7:0] REQ_BYTE = REQ_BYTE_DEF,
  parameter logic [7:0] HDR_BYTE = HDR_BYTE_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx_pin,
  output logic        tx_pin,
  input  logic        set_en,
  input  logic [31:0] set_value,
  output logic [31:0] epoch,
  output logic        busy,
  output logic        req_drop
);

  localparam int BIT_CYC = CLK_HZ / BAUD;
  localparam int HALF    = BIT_CYC / 2;
  localparam int CW      = $clog2(BIT_CYC + 1);
  localparam int PW      = $clog2(CLK_HZ + 1);

  // ---------------- epoch counter ----------------
  logic [PW-1:0] r_presc;
  logic [31:0]   r_epoch;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_presc <= '0;
      r_epoch <= '0;
    end else if (set_en) begin
      // a load outranks a tick landing in the same cycle
      r_presc <= '0;
      r_epoch <= set_value;
    end else if (r_presc == PW'(CLK_HZ - 1)) begin
      r_presc <= '0;
      r_epoch <= r_epoch + 32'd1;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  assign epoch = r_epoch;

  // ---------------- receiver ----------------
  logic          r_rx_s1;
  logic          r_rx_s2;
  logic          r_rx_prev;
  rx_state_t     r_rx_st;
  logic [CW-1:0] r_rx_cnt;
  logic [2:0]    r_rx_bit;
  logic [7:0]    r_rx_data;
  logic          w_rx_fall;
  logic          w_rx_bit_end;
  logic          w_accept;

  assign w_rx_fall    = r_rx_prev && !r_rx_s2;
  assign w_rx_bit_end = (r_rx_cnt == CW'(BIT_CYC - 1));
  // Good stop bit on a request byte; valid for exactly the stop-sample cycle.
  assign w_accept     = (r_rx_st == RX_STOP) && w_rx_bit_end && r_rx_s2 &&
                        (r_rx_data == REQ_BYTE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
      r_rx_st   <= RX_IDLE;
      r_rx_cnt  <= '0;
      r_rx_bit  <= '0;
    end else begin
      r_rx_s1   <= rx_pin;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
      case (r_rx_st)
        RX_IDLE: begin
          if (w_rx_fall) begin
            r_rx_st  <= RX_START;
            r_rx_cnt <= '0;
          end
        end
        RX_START: begin
          // mid-start-bit check rejects short glitches
          if (r_rx_cnt == CW'(HALF - 1)) begin
            r_rx_cnt <= '0;
            r_rx_bit <= '0;
            r_rx_st  <= r_rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (w_rx_bit_end) begin
            r_rx_cnt <= '0;
            if (r_rx_bit == 3'd7) r_rx_st <= RX_STOP;
            else r_rx_bit <= r_rx_bit + 3'd1;
          end else begin
            r_rx_cnt <= r_rx_cnt + CW'(1);
          end
        end
        RX_STOP: begin
          // a low stop bit simply drops the byte: w_accept stays low
          if (w_rx_bit_end) begin
            r_rx_cnt <= '0;
            r_rx_st  <= RX_IDLE;
          end else begin
            r_rx_cnt <= r_rx_cnt + CW'(1);
          end
        end
        default: r_rx_st <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((r_rx_st == RX_DATA) && w_rx_bit_end) begin
      r_rx_data <= {r_rx_s2, r_rx_data[7:1]};
    end
  end

  // ---------------- frame sequencer ----------------
  tx_state_t   r_tx_st;
  logic [2:0]  r_idx;
  logic [31:0] r_snap;
  logic        r_busy;
  logic        r_drop;
  logic        w_tx_idle;
  logic        w_byte_start;
  logic        w_byte_ready;
  logic [7:0]  w_byte_data;

  assign w_tx_idle    = (r_tx_st == TX_IDLE);
  assign w_byte_start = (r_tx_st == TX_SEND) && (r_idx != 3'(FRAME_BYTES));

  // PEND spends one cycle between accept and the first start request so the
  // start bit appears two cycles after the stop-bit sample.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_tx_st <= TX_IDLE;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_drop <= w_accept && !w_tx_idle;
      case (r_tx_st)
        TX_IDLE: begin
          if (w_accept) r_tx_st <= TX_PEND;
        end
        TX_PEND: begin
          r_tx_st <= TX_SEND;
          r_idx   <= '0;
        end
        TX_SEND: begin
          if (w_byte_ready) begin
            if (r_idx == 3'(FRAME_BYTES)) begin
              // ready here marks the end of the final stop bit
              r_tx_st <= TX_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_idx <= r_idx + 3'd1;
              if (r_idx == 3'd0) r_busy <= 1'b1;
            end
          end
        end
        default: r_tx_st <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept && w_tx_idle) r_snap <= r_epoch;
  end

`ifdef TIME_RESP_CHECKSUM_EN
  logic [7:0] w_chk;
  assign w_chk = r_snap[31:24] ^ r_snap[23:16] ^ r_snap[15:8] ^ r_snap[7:0];
`endif

  always_comb begin
    w_byte_data = HDR_BYTE;
    case (r_idx)
      3'd1:    w_byte_data = r_snap[31:24];
      3'd2:    w_byte_data = r_snap[23:16];
      3'd3:    w_byte_data = r_snap[15:8];
      3'd4:    w_byte_data = r_snap[7:0];
`ifdef TIME_RESP_CHECKSUM_EN
      3'd5:    w_byte_data = w_chk;
`endif
      default: w_byte_data = HDR_BYTE;
    endcase
  end

  uart_byte_tx #(
    .BIT_CYC(BIT_CYC)
  ) u_byte_tx (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (w_byte_start),
    .data   (w_byte_data),
    .ready  (w_byte_ready),
    .tx     (tx_pin)
  );

  assign busy     = r_busy;
  assign req_drop = r_drop;

endmodule

// File: tb/tb_uart_time_responder.sv
// Bench for uart_time_responder at CLK_HZ=1600, BAUD=100 (16 cycles per bit).
// Stimulus drives UART bytes on rx_pin; a reference model of the epoch counter and
// of the request/response rules pushes expected frames into a queue, and an
// independent line monitor decodes tx_pin and compares.
module tb_uart_time_responder;
  import time_link_pkg::*;

  localparam int CLK_HZ  = 1600;
  localparam int BAUD    = 100;
  localparam int BIT_CYC = CLK_HZ / BAUD;
  localparam int FB      = FRAME_BYTES;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx_pin = 1'b1;
  logic        tx_pin;
  logic        set_en = 1'b0;
  logic [31:0] set_value = '0;
  logic [31:0] epoch;
  logic        busy;
  logic        req_drop;

  uart_time_responder #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .rx_pin   (rx_pin),
    .tx_pin   (tx_pin),
    .set_en   (set_en),
    .set_value(set_value),
    .epoch    (epoch),
    .busy     (busy),
    .req_drop (req_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          start;
    logic [47:0] bytes;
  } frame_t;

  int          cyc = 0;
  int          checks = 0;
  int          fails = 0;
  logic [31:0] ep_hist [0:131071];
  logic [31:0] m_base = '0;
  int          m_base_cyc = 0;
  frame_t      exp_q[$];
  int          exp_drops = 0;
  int          drop_seen = 0;
  int          busy_until = 0;
  int          busy_cyc = 0;
  int          txlow_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [47:0] mk_frame(input logic [31:0] s);
    return {HDR_BYTE_DEF, s, s[31:24] ^ s[23:16] ^ s[15:8] ^ s[7:0]};
  endfunction

  // Epoch reference: value visible after edge c is the last load plus whole seconds since.
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
    if (!reset_n) begin
      m_base = '0;
      m_base_cyc = cyc;
    end else if (set_en) begin
      m_base = set_value;
      m_base_cyc = cyc;
    end
    if (cyc < 131072) ep_hist[cyc] = m_base + 32'((cyc - m_base_cyc) / CLK_HZ);
  end

  initial forever begin
    @(negedge clk);
    if (busy === 1'b1) busy_cyc++;
    if (tx_pin !== 1'b1) txlow_cyc++;
    if (req_drop === 1'b1) drop_seen++;
  end

  // Line monitor: decode a whole frame from tx_pin at bit centres.
  initial forever begin
    @(negedge clk);
    if (reset_n && tx_pin === 1'b0) begin
      int          st;
      logic [59:0] bits;
      logic        bz_ok;
      logic        ab;
      frame_t      f;
      logic [7:0]  d;
      st = cyc;
      bits = '0;
      bz_ok = 1'b1;
      ab = 1'b0;
      for (int j = 0; j < FB * 10; j++) begin
        while (!ab && cyc < st + BIT_CYC * j + 8) begin
          @(negedge clk);
          if (!reset_n) ab = 1'b1;
        end
        if (ab) break;
        bits[j] = tx_pin;
        if (busy !== 1'b1) bz_ok = 1'b0;
      end
      if (ab) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        while (!reset_n) @(negedge clk);
      end else begin
        while (cyc < st + FB * BIT_CYC * 10 - 1) @(negedge clk);
        check("busy_before_end", busy, 1'b1);
        @(negedge clk);
        check("busy_after_end", busy, 1'b0);
        check("tx_idle_after_end", tx_pin, 1'b1);
        check("busy_during_frame", bz_ok, 1'b1);
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_frame: frame started at cycle %0d, none expected", st);
        end else begin
          f = exp_q.pop_front();
          check("frame_start_cycle", st, f.start);
          for (int i = 0; i < FB; i++) begin
            for (int m = 0; m < 8; m++) d[m] = bits[10 * i + 1 + m];
            check($sformatf("start_bit[%0d]", i), bits[10 * i], 1'b0);
            check($sformatf("stop_bit[%0d]", i), bits[10 * i + 9], 1'b1);
            check($sformatf("byte[%0d]", i), d, f.bytes[47 - 8 * i -: 8]);
          end
        end
      end
    end
  end

  // All stimulus tasks start and end just after a falling clock edge.
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_set(input logic [31:0] v);
    set_en = 1'b1;
    set_value = v;
    @(negedge clk);
    set_en = 1'b0;
  endtask

  // Line falls before edge k; returns with the stop bit just finished.
  task automatic send_byte(input logic [7:0] b, input logic stop, output int k);
    rx_pin = 1'b0;
    k = cyc + 1;
    @(negedge clk);
    set_en = 1'b0;
    repeat (BIT_CYC - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_pin = b[i];
      repeat (BIT_CYC) @(negedge clk);
    end
    rx_pin = stop;
    repeat (BIT_CYC) @(negedge clk);
    rx_pin = 1'b1;
  endtask

  // Stop-bit centre is 9.5 bits after the falling edge (k+152), seen two cycles
  // later through the synchroniser (accept at k+154); the response start bit
  // follows 2 cycles after that and the frame holds the transmitter for
  // 10*FB bit times, after which a new request can be taken.
  task automatic send_req(input logic [7:0] b, input logic stop);
    int     k;
    int     a;
    frame_t f;
    send_byte(b, stop, k);
    if (b == REQ_BYTE_DEF && stop) begin
      a = k + 9 * BIT_CYC + BIT_CYC / 2 + 2;
      if (a >= busy_until) begin
        f.start = a + 2;
        f.bytes = mk_frame(ep_hist[a - 1]);
        exp_q.push_back(f);
        busy_until = a + 3 + FB * 10 * BIT_CYC;
      end else begin
        exp_drops++;
      end
    end
  endtask

  task automatic wait_frames();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 4000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL frame_timeout: %0d expected frame(s) never seen", exp_q.size());
      exp_q.delete();
    end
    wait_cyc(4);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int          b0;
    int          t0;
    int          d0;
    int          tk;
    int          e0;
    logic [7:0]  rb;
    logic        rs;

    // reset state
    reset_n = 1'b0;
    wait_cyc(3);
    check("rst_tx_pin", tx_pin, 1'b1);
    check("rst_epoch", epoch, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_req_drop", req_drop, 1'b0);
    reset_n = 1'b1;
    wait_cyc(5);

    // 1: basic request
    do_set(32'h6500_0000);
    wait_cyc(3);
    check("epoch_after_set", epoch, 32'h6500_0000);
    send_req(8'h54, 1'b1);
    wait_frames();

    // 2: epoch wrap
    do_set(32'hFFFF_FFFF);
    wait_cyc(CLK_HZ - 1);
    check("epoch_before_wrap", epoch, 32'hFFFF_FFFF);
    wait_cyc(1);
    check("epoch_wrap", epoch, 32'h0);
    send_req(8'h54, 1'b1);
    wait_frames();

    // 3: non-request byte, glitch, framing error -> silence
    b0 = busy_cyc;
    t0 = txlow_cyc;
    send_req(8'h41, 1'b1);
    wait_cyc(20);
    rx_pin = 1'b0;
    wait_cyc(6);
    rx_pin = 1'b1;
    wait_cyc(40);
    send_req(8'h54, 1'b0);
    wait_cyc(200);
    check("ignored_busy_cycles", busy_cyc - b0, 0);
    check("ignored_tx_low_cycles", txlow_cyc - t0, 0);

    // 4: request while busy
    d0 = drop_seen;
    send_req(8'h54, 1'b1);
    wait_cyc(100);
    send_req(8'h54, 1'b1);
    wait_frames();
    wait_cyc(900);
    check("single_drop_pulse", drop_seen - d0, 1);

    // 5: set and tick in the same cycle, request starting there too
    tk = m_base_cyc + CLK_HZ * ((cyc + 1 - m_base_cyc) / CLK_HZ + 1);
    while (cyc != tk - 1) @(negedge clk);
    set_en = 1'b1;
    set_value = 32'h1234_5678;
    send_req(8'h54, 1'b1);
    check("set_beats_tick", epoch, 32'h1234_5678);
    wait_frames();

    // 6: reset during byte 3 of a frame
    send_req(8'h54, 1'b1);
    e0 = exp_q[$].start;
    while (cyc < e0 + 2 * 10 * BIT_CYC + 10) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("midframe_rst_tx", tx_pin, 1'b1);
    check("midframe_rst_busy", busy, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    busy_until = 0;
    wait_cyc(20);
    send_req(8'h54, 1'b1);
    wait_frames();

    // randomized traffic
    for (int i = 0; i < 16; i++) begin
      wait_cyc($urandom_range(1, 600));
      if ($urandom_range(0, 3) == 0) do_set($urandom);
      rb = ($urandom_range(0, 3) == 0) ? 8'($urandom) : REQ_BYTE_DEF;
      rs = ($urandom_range(0, 7) != 0);
      send_req(rb, rs);
    end
    wait_frames();
    wait_cyc(900);
    check("epoch_model", epoch, ep_hist[cyc]);
    check("total_drops", drop_seen, exp_drops);

    $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
    $finish;
  end

endmodule
